mem_stage_bus: RTL and testbench

- Parametrised, sequential successor to the combinational memory-stage mux.
- Accepts one load/store per transaction from the memory pipeline stage over a valid/ready handshake and strobes exactly one of NUM_CH memory channels (call stack, main memory, program memory, framebuffer, ...).
- Waits a per-channel configurable read latency, then returns registered, zero-extended read data with a response pulse.
- Rejects writes to read-only channels and out-of-range channel indices with an error response.

---
 rtl/mem_stage_bus.sv | 166 ++++++++++++++++
 tb/tb_mem_stage_bus.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_bus.sv
// Memory-stage bus: one load/store at a time, strobes one channel, waits its read latency, responds.
// Optional MEM_STAGE_BUS_STATS_EN adds saturating read/write/error response counters.
module mem_stage_bus #(
  parameter int          ADDR_W = 17,
  parameter int          DATA_W = 12,
  parameter int          NUM_CH = 4,
  parameter int          CH_W   = 2,
  parameter logic [15:0] CH_LAT = 16'h5555,
  parameter logic [7:0]  CH_RO  = 8'b0000_0100
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wen,
  input  logic [CH_W-1:0]          req_ch,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        ch_wen,
  output logic [ADDR_W-1:0]        ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  output logic [1:0]               dbg_state
`ifdef MEM_STAGE_BUS_STATS_EN
  ,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count,
  output logic [15:0]              err_count
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, WAIT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                wen_q;
  logic [CH_W-1:0]     ch_q;
  logic [1:0]          cnt_q;
  logic                in_range, ro_hit, req_err, accept;
  logic [NUM_CH-1:0]   req_onehot;
  logic [1:0]          lat_fld, lat_eff;
  logic [DATA_W-1:0]   rdata_sel;

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // req_ready depends on state only, so the requester may hold valid with no feedback path.
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign dbg_state = state_q;

  always_comb begin
    in_range   = 1'b0;
    ro_hit     = 1'b0;
    req_onehot = '0;
    lat_fld    = 2'd1;
    rdata_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_ch == CH_W'(i)) begin
        in_range      = 1'b1;
        ro_hit        = CH_RO[i];
        req_onehot[i] = 1'b1;
      end
      if (ch_q == CH_W'(i)) begin
        lat_fld   = CH_LAT[2*i +: 2];
        rdata_sel = ch_rdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign req_err = ~in_range | (req_wen & ro_hit);
  // A zero latency field would leave no cycle for the memory to answer.
  assign lat_eff = (lat_fld == 2'd0) ? 2'd1 : lat_fld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !req_err) state_d = STROBE;
      STROBE:  state_d = wen_q ? IDLE : WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wen_q     <= 1'b0;
      ch_q      <= '0;
      cnt_q     <= '0;
      ch_en     <= '0;
      ch_wen    <= '0;
      ch_addr   <= '0;
      ch_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ch_en     <= '0;
      ch_wen    <= '0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            wen_q <= req_wen;
            ch_q  <= req_ch;
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              ch_en    <= req_onehot;
              ch_wen   <= req_wen ? req_onehot : '0;
              ch_addr  <= req_addr;
              ch_wdata <= req_wdata;
            end
          end
        end
        STROBE: begin
          if (wen_q) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt_q <= lat_eff - 2'd1;
          end
        end
        WAIT: begin
          // The last WAIT cycle is the one in which the channel's data is valid.
          if (cnt_q == 2'd0) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_sel;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_STAGE_BUS_STATS_EN
  // wen_q still describes the responding transaction during its rsp_valid cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (rsp_valid) begin
      if (rsp_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (wen_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_bus.sv
// Bench for mem_stage_bus: 3 channels (ch2 read-only), latencies ch0=field 0 (->1), ch1=3, ch2=2.
// A transaction-level model predicts response cycles, strobes and data; literals pin key cases.
module tb_mem_stage_bus;
  localparam int ADDR_W = 17;
  localparam int W      = 12;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_wen = 1'b0;
  logic [CH_W-1:0]     req_ch = '0;
  logic [ADDR_W-1:0]   req_addr = '0;
  logic [W-1:0]        req_wdata = '0;
  logic                rsp_valid, rsp_err;
  logic [W-1:0]        rsp_rdata;
  logic [NUM_CH-1:0]   ch_en, ch_wen;
  logic [ADDR_W-1:0]   ch_addr;
  logic [W-1:0]        ch_wdata;
  logic [NUM_CH*W-1:0] ch_rdata = '0;
  logic [1:0]          dbg_state;
`ifdef MEM_STAGE_BUS_STATS_EN
  logic [15:0]         rd_count, wr_count, err_count;
`endif

  mem_stage_bus #(
    .ADDR_W(ADDR_W), .DATA_W(W), .NUM_CH(NUM_CH), .CH_W(CH_W),
    .CH_LAT(16'h556C), .CH_RO(8'b0000_0100)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_ch(req_ch), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ch_en(ch_en), .ch_wen(ch_wen), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .dbg_state(dbg_state)
`ifdef MEM_STAGE_BUS_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int              lat_tab[4] = '{1, 3, 2, 0};
  bit              ro_tab[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
  int              exp_cyc_q[$];
  logic            exp_err_q[$];
  logic [W-1:0]    exp_q[$];
  int              busy_until = 0;
  int              strobe_cyc = -1;
  logic [NUM_CH-1:0] m_en = '0, m_wen = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [W-1:0]    m_wdata = '0, m_rdata = '0;
  int              samp_cyc = -1;
  int              samp_ch = 0;
  logic [W-1:0]    samp_val = '0;
  int              m_rd = 0, m_wr = 0, m_err = 0;
  bit              due;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic model_reset();
    exp_cyc_q.delete();
    exp_err_q.delete();
    exp_q.delete();
    busy_until = 0;
    strobe_cyc = -1;
    m_en = '0; m_wen = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    samp_cyc = -1;
    m_rd = 0; m_wr = 0; m_err = 0;
  endtask

  // channel memories: rval only in the one cycle the DUT must sample it
  always @(negedge clock) begin
    #1;
    for (int i = 0; i < NUM_CH; i++)
      ch_rdata[W*i +: W] = (cyc == samp_cyc && samp_ch == i) ? samp_val : (12'hF00 ^ W'(cyc));
  end

  // scoreboard compare, every cycle
  always @(negedge clock) begin
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      void'(exp_cyc_q.pop_front()); void'(exp_err_q.pop_front()); void'(exp_q.pop_front());
    end
    due = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
    chk("req_ready", 32'(req_ready), 32'(cyc >= busy_until));
    chk("ch_en", 32'(ch_en), (cyc == strobe_cyc) ? 32'(m_en) : 32'd0);
    chk("ch_wen", 32'(ch_wen), (cyc == strobe_cyc) ? 32'(m_wen) : 32'd0);
    chk("ch_addr", 32'(ch_addr), 32'(m_addr));
    chk("ch_wdata", 32'(ch_wdata), 32'(m_wdata));
    chk("rsp_valid", 32'(rsp_valid), 32'(due));
`ifdef MEM_STAGE_BUS_STATS_EN
    chk("rd_count", 32'(rd_count), 32'(m_rd));
    chk("wr_count", 32'(wr_count), 32'(m_wr));
    chk("err_count", 32'(err_count), 32'(m_err));
`endif
    if (due) begin
      chk("rsp_err", 32'(rsp_err), 32'(exp_err_q[0]));
      m_rdata = exp_q[0];
      if (exp_err_q[0]) m_err++;
      else if (strobe_cyc >= 0 && m_wen != '0 && exp_q[0] == '0 && cyc == strobe_cyc + 1) m_wr++;
      else m_rd++;
      void'(exp_cyc_q.pop_front()); void'(exp_err_q.pop_front()); void'(exp_q.pop_front());
    end else begin
      chk("rsp_err_idle", 32'(rsp_err), 32'd0);
    end
    chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
  end

  // driver: issue one request once the model says the block is idle
  task automatic send(input logic wen, input int ch, input logic [ADDR_W-1:0] addr,
                      input logic [W-1:0] wdata, input logic [W-1:0] rval);
    int t;
    int guard;
    bit err;
    guard = 0;
    while (cyc < busy_until && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 32'd0, 32'd1);
    t = cyc;
    req_valid = 1'b1; req_wen = wen; req_ch = CH_W'(ch); req_addr = addr; req_wdata = wdata;
    err = (ch >= NUM_CH) || (wen && ro_tab[ch]);
    if (err) begin
      exp_cyc_q.push_back(t + 1); exp_err_q.push_back(1'b1); exp_q.push_back('0);
      busy_until = t + 1;
    end else begin
      strobe_cyc = t + 1;
      m_en   = NUM_CH'(1) << ch;
      m_wen  = wen ? m_en : '0;
      m_addr = addr;
      m_wdata = wdata;
      if (wen) begin
        exp_cyc_q.push_back(t + 2); exp_err_q.push_back(1'b0); exp_q.push_back('0);
        busy_until = t + 2;
      end else begin
        samp_cyc = t + 1 + lat_tab[ch];
        samp_ch  = ch;
        samp_val = rval;
        exp_cyc_q.push_back(t + 2 + lat_tab[ch]); exp_err_q.push_back(1'b0); exp_q.push_back(rval);
        busy_until = t + 2 + lat_tab[ch];
      end
    end
    step();
    req_valid = 1'b0;
    req_wen = 1'(($urandom_range(0, 1)));
    req_addr = ADDR_W'($urandom_range(0, 131071));
    req_wdata = W'($urandom_range(0, 4095));
  endtask

  int t0;

  initial begin
    repeat (3) step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_en", 32'(ch_en), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    reset_n = 1'b1;
    step();

    // write main memory
    send(1'b1, 1, 17'h00123, 12'h0AB, 12'h000);
    chk("wr_en_lit", 32'(ch_en), 32'h2);
    chk("wr_wen_lit", 32'(ch_wen), 32'h2);
    chk("wr_addr_lit", 32'(ch_addr), 32'h00123);
    chk("wr_wdata_lit", 32'(ch_wdata), 32'h0AB);
    step();
    chk("wr_rsp_lit", 32'({rsp_valid, rsp_err}), 32'h2);

    // read ch1, latency 3, junk request held while busy
    send(1'b0, 1, 17'h00456, 12'h000, 12'h05A);
    req_valid = 1'b1; req_wen = 1'b1; req_ch = 2'd0; req_addr = 17'h1FFFF; req_wdata = 12'hFFF;
    chk("rd3_busy1", 32'(req_ready), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      step();
      if (k == 4) req_valid = 1'b0;
      chk("rd3_busy", 32'(req_ready), 32'd0);
      chk("rd3_early", 32'(rsp_valid), 32'd0);
    end
    step();
    chk("rd3_rsp_lit", 32'({rsp_valid, rsp_err}), 32'h2);
    chk("rd3_data_lit", 32'(rsp_rdata), 32'h05A);

    // write to read-only channel
    send(1'b1, 2, 17'h00010, 12'h777, 12'h000);
    chk("ro_rsp_lit", 32'({rsp_valid, rsp_err}), 32'h3);
    chk("ro_en_lit", 32'(ch_en), 32'd0);

    // read read-only channel, latency 2
    send(1'b0, 2, 17'h00020, 12'h000, 12'h03C);
    repeat (3) step();
    chk("ro_rd_lit", 32'({rsp_valid, rsp_err}), 32'h2);
    chk("ro_rd_data_lit", 32'(rsp_rdata), 32'h03C);

    // out-of-range channel
    send(1'b0, 3, 17'h00030, 12'h000, 12'h000);
    chk("oor_rsp_lit", 32'({rsp_valid, rsp_err}), 32'h3);
    chk("oor_rdata_lit", 32'(rsp_rdata), 32'h000);

    // ch0 latency field 0 behaves as 1
    send(1'b0, 0, 17'h00ABC, 12'h000, 12'h9C1);
    repeat (2) step();
    chk("lat0_rsp_lit", 32'(rsp_valid), 32'd1);
    chk("lat0_data_lit", 32'(rsp_rdata), 32'h9C1);
    step();

    // back-to-back: write accepted in the read's response cycle
    t0 = cyc;
    send(1'b0, 0, 17'h00100, 12'h000, 12'h321);
    send(1'b1, 1, 17'h00200, 12'h456, 12'h000);
    chk("b2b_accept_lit", 32'(cyc), 32'(t0 + 4));
    step();
    chk("b2b_wr_rsp_lit", 32'({rsp_valid, rsp_err}), 32'h2);
    chk("b2b_rdata_lit", 32'(rsp_rdata), 32'h000);
    step();
`ifdef MEM_STAGE_BUS_STATS_EN
    chk("rd_count_lit", 32'(rd_count), 32'd4);
    chk("wr_count_lit", 32'(wr_count), 32'd2);
    chk("err_count_lit", 32'(err_count), 32'd2);
`endif

    // a few more directed mixes
    send(1'b1, 0, 17'h1FFFF, 12'hFFF, 12'h000);
    send(1'b0, 2, 17'h00000, 12'h000, 12'hA5A);
    send(1'b1, 2, 17'h00001, 12'h001, 12'h000);
    send(1'b0, 1, 17'h0F0F0, 12'h000, 12'h7E7);
    send(1'b1, 1, 17'h00001, 12'h800, 12'h000);
    repeat (6) step();

    // reset during WAIT discards the read
    send(1'b0, 1, 17'h00777, 12'h000, 12'h5A5);
    step();
    #1;
    reset_n = 1'b0;
    model_reset();
    step();
    chk("mid_rst_en", 32'(ch_en), 32'd0);
    chk("mid_rst_addr", 32'(ch_addr), 32'd0);
    chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;
    repeat (6) step();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rsp", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
